// File: rtl/fb_fill_writer.sv
// fb_fill_writer: clipped rectangle fill, one pixel write per clock into a 64x64 framebuffer.
// Define FB_VBLANK_SYNC_EN to hold each non-empty fill until vertical blanking.
module fb_fill_writer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_cmd_x,
    input  logic [5:0]  i_cmd_y,
    input  logic [6:0]  i_cmd_w,
    input  logic [6:0]  i_cmd_h,
    input  logic [11:0] i_cmd_color,
    input  logic        i_vblank,
    output logic        o_we,
    output logic [11:0] o_waddr,
    output logic [11:0] o_wdata,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
`ifdef FB_VBLANK_SYNC_EN
        S_WAIT_VB = 2'd1,
`endif
        S_FILL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_x0;
    logic [5:0]  r_xl;
    logic [5:0]  r_yl;
    logic [5:0]  r_col;
    logic [5:0]  r_row;
`ifdef FB_VBLANK_SYNC_EN
    logic [11:0] r_color;
`else
    logic        w_unused_vblank;
    assign w_unused_vblank = i_vblank;
`endif

    logic [6:0]  w_room_x;
    logic [6:0]  w_room_y;
    logic [6:0]  w_cw;
    logic [6:0]  w_ch;
    logic [5:0]  w_xl;
    logic [5:0]  w_yl;
    logic        w_empty;
    logic        w_accept;
    logic        w_row_end;
    logic [5:0]  w_ncol;
    logic [5:0]  w_nrow;

    // Clip against the right/bottom edge so the raster never wraps rows.
    assign w_room_x  = 7'd64 - {1'b0, i_cmd_x};
    assign w_room_y  = 7'd64 - {1'b0, i_cmd_y};
    assign w_cw      = (i_cmd_w < w_room_x) ? i_cmd_w : w_room_x;
    assign w_ch      = (i_cmd_h < w_room_y) ? i_cmd_h : w_room_y;
    assign w_xl      = i_cmd_x + w_cw[5:0] - 6'd1;
    assign w_yl      = i_cmd_y + w_ch[5:0] - 6'd1;
    assign w_empty   = (w_cw == 7'd0) || (w_ch == 7'd0);
    assign w_accept  = i_cmd_valid && o_cmd_ready;

    assign w_row_end = (r_col == r_xl);
    assign w_ncol    = w_row_end ? r_x0 : r_col + 6'd1;
    assign w_nrow    = w_row_end ? r_row + 6'd1 : r_row;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_x0        <= 6'd0;
            r_xl        <= 6'd0;
            r_yl        <= 6'd0;
            r_col       <= 6'd0;
            r_row       <= 6'd0;
`ifdef FB_VBLANK_SYNC_EN
            r_color     <= 12'd0;
`endif
            o_cmd_ready <= 1'b1;
            o_we        <= 1'b0;
            o_waddr     <= 12'd0;
            o_wdata     <= 12'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_we   <= 1'b0;
            o_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        r_x0        <= i_cmd_x;
                        r_xl        <= w_xl;
                        r_yl        <= w_yl;
                        r_col       <= i_cmd_x;
                        r_row       <= i_cmd_y;
                        if (w_empty) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else begin
`ifdef FB_VBLANK_SYNC_EN
                            r_color <= i_cmd_color;
                            r_state <= S_WAIT_VB;
`else
                            r_state <= S_FILL;
                            o_we    <= 1'b1;
                            o_waddr <= {i_cmd_y, i_cmd_x};
                            o_wdata <= i_cmd_color;
`endif
                        end
                    end
                end
`ifdef FB_VBLANK_SYNC_EN
                S_WAIT_VB: begin
                    if (i_vblank) begin
                        r_state <= S_FILL;
                        o_we    <= 1'b1;
                        o_waddr <= {r_row, r_col};
                        o_wdata <= r_color;
                    end
                end
`endif
                S_FILL: begin
                    // The write on the bus is (r_col, r_row); advance or finish.
                    if (w_row_end && (r_row == r_yl)) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        o_we    <= 1'b1;
                        o_waddr <= {w_nrow, w_ncol};
                        r_col   <= w_ncol;
                        r_row   <= w_nrow;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
